hgcal_input_quantizer: RTL and testbench

- Upstream feeder for the HGCAL autoencoder layer0 LUT neurons.
- Accepts a stream of raw unsigned sensor-cell charge words, one per handshake.
- Quantizes each word to a Q_WIDTH-bit code and packs one full frame of NUM_INPUTS codes into a wide vector.
- Each layer0 neuron takes its fan-in slices from that vector; buffering lets frame k+1 collect while frame k waits for consumption.

---
 rtl/hgcal_quant_pkg.sv | 21 ++
 rtl/hgcal_quant_cell.sv | 35 +++
 rtl/hgcal_input_quantizer.sv | 101 ++++++++++
 tb/tb_hgcal_input_quantizer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_quant_pkg.sv
// Shared constants and types for the HGCAL layer0 input quantizer.
// Optional build macro: HGCAL_QUANT_ROUND_EN (round half-up before the shift).
package hgcal_quant_pkg;

    localparam int unsigned NUM_INPUTS = 48;
    localparam int unsigned IN_WIDTH   = 16;
    localparam int unsigned Q_WIDTH    = 2;
    localparam int unsigned SHIFT      = 8;

    localparam int unsigned QMAX       = (1 << Q_WIDTH) - 1;
    localparam int unsigned IDX_W      = $clog2(NUM_INPUTS);
    localparam int unsigned OUT_WIDTH  = NUM_INPUTS * Q_WIDTH;
    localparam int unsigned SEL_W      = $clog2(OUT_WIDTH);
    localparam int unsigned ROUND_BIAS = 1 << (SHIFT - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_e;

endpackage

// File: rtl/hgcal_quant_cell.sv
// Combinational shift / optional round / saturate of one raw charge word.
// Optional build macro: HGCAL_QUANT_ROUND_EN selects round half-up.
module hgcal_quant_cell
    import hgcal_quant_pkg::*;
(
    input  logic [IN_WIDTH-1:0] din,
    output logic [Q_WIDTH-1:0]  q_c
);

    localparam int unsigned SW = IN_WIDTH + 1;

    logic [SW-1:0] scaled_c;

`ifdef HGCAL_QUANT_ROUND_EN
    // Add half an LSB in a widened adder so all-ones input cannot wrap.
    always_comb begin
        scaled_c = ({1'b0, din} + SW'(ROUND_BIAS)) >> SHIFT;
    end
`else
    // Plain truncating scale.
    always_comb begin
        scaled_c = {1'b0, din} >> SHIFT;
    end
`endif

    // Clamp to the largest code.
    always_comb begin
        if (scaled_c > SW'(QMAX)) begin
            q_c = Q_WIDTH'(QMAX);
        end else begin
            q_c = scaled_c[Q_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Quantizes a raw charge stream and packs full frames for the layer0 neurons.
// A fill buffer collects frame k+1 while frame k waits in the output slot.
// Optional build macro: HGCAL_QUANT_ROUND_EN (see hgcal_quant_cell).
module hgcal_input_quantizer
    import hgcal_quant_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 err_frame
);

    fill_state_e          state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [OUT_WIDTH-1:0] fill_q;

    logic [Q_WIDTH-1:0]   q_c;
    logic                 accept_c;
    logic                 slot_free_c;
    logic                 last_slot_c;
    logic [SEL_W-1:0]     base_c;
    logic [OUT_WIDTH-1:0] fill_wr_c;

    hgcal_quant_cell u_cell (
        .din (in_data),
        .q_c (q_c)
    );

    // Ready only while collecting and out of reset.
    assign in_ready    = rst && (state_q == FILL);
    assign accept_c    = in_valid && in_ready;
    assign slot_free_c = !out_valid || out_ready;
    assign last_slot_c = (idx_q == IDX_W'(NUM_INPUTS - 1));
    assign base_c      = SEL_W'(idx_q) * SEL_W'(Q_WIDTH);

    // Fill buffer with the current code merged into its slot.
    always_comb begin
        fill_wr_c = fill_q;
        fill_wr_c[base_c +: Q_WIDTH] = q_c;
    end

    // Fill-state FSM, index counter, fill buffer and output slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    if (accept_c) begin
                        if (last_slot_c) begin
                            err_frame <= !in_last;
                            if (slot_free_c) begin
                                out_data  <= fill_wr_c;
                                out_valid <= 1'b1;
                                idx_q     <= '0;
                                fill_q    <= fill_wr_c;
                            end else begin
                                fill_q  <= fill_wr_c;
                                state_q <= HOLD;
                            end
                        end else if (in_last) begin
                            err_frame <= 1'b1;
                            idx_q     <= '0;
                            fill_q    <= '0;
                        end else begin
                            fill_q <= fill_wr_c;
                            idx_q  <= idx_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (slot_free_c) begin
                        out_data  <= fill_q;
                        out_valid <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed bench for hgcal_input_quantizer.
module tb_hgcal_input_quantizer;
    import hgcal_quant_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 err_frame;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int err_pulses = 0;

    hgcal_input_quantizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_frame (err_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_frame === 1'b1) err_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus patterns: 0 alternates 0x0180/0x5000, 1 and 2 walk a boundary table.
    function automatic logic [IN_WIDTH-1:0] word_for(input int pat, input int k);
        int j;
        if (pat == 0) return (k % 2 == 0) ? 16'h0180 : 16'h5000;
        j = (pat == 1) ? (k % 8) : ((k + 3) % 8);
        case (j)
            0:       return 16'h0000;
            1:       return 16'h00FF;
            2:       return 16'h0100;
            3:       return 16'h01FF;
            4:       return 16'h0200;
            5:       return 16'h02FF;
            6:       return 16'h0300;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [Q_WIDTH-1:0] model_q(input logic [IN_WIDTH-1:0] d);
        logic [IN_WIDTH:0] v;
`ifdef HGCAL_QUANT_ROUND_EN
        v = ({1'b0, d} + 17'd128) >> 8;
`else
        v = {1'b0, d} >> 8;
`endif
        if (v > 17'd3) return 2'd3;
        return v[1:0];
    endfunction

    function automatic logic [OUT_WIDTH-1:0] exp_frame(input int pat);
        logic [OUT_WIDTH-1:0] f;
        f = '0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) f[k*2 +: 2] = model_q(word_for(pat, k));
        return f;
    endfunction

    // Drive words start..start+n-1; in_last on index last_at (-1 for none).
    task automatic send_words(input int start, input int n, input int pat, input int last_at);
        int budget;
        for (int k = start; k < start + n; k++) begin
            in_valid = 1'b1;
            in_data  = word_for(pat, k);
            in_last  = (k == last_at);
            budget   = 0;
            while (!in_ready && budget < 100) begin
                tick();
                budget++;
                stalls++;
            end
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: word %0d got in_ready=%b want 1", k, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_frame); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int e0;
        logic [OUT_WIDTH-1:0] exp;
        logic [1:0] s0;
        logic [1:0] s1;
        exp = '0;
        for (int k = 0; k < int'(NUM_INPUTS); k++) begin
`ifdef HGCAL_QUANT_ROUND_EN
            exp[k*2 +: 2] = (k % 2 == 0) ? 2'b10 : 2'b11;
`else
            exp[k*2 +: 2] = (k % 2 == 0) ? 2'b01 : 2'b11;
`endif
        end
        out_ready = 1'b1;
        e0 = err_pulses;
        send_words(0, 47, 0, 47);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early_valid: got %b want 0", out_valid); end
        send_words(47, 1, 0, 47);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        s0 = out_data[1:0];
        s1 = out_data[3:2];
        checks++; if (s0 !== exp[1:0]) begin errors++; $display("FAIL basic_slice0: got %b want %b", s0, exp[1:0]); end
        checks++; if (s1 !== 2'b11) begin errors++; $display("FAIL basic_slice1: got %b want 11", s1); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL basic_data: got %h want %h", out_data, exp); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_pulses - e0); end
    endtask

    task automatic test_boundaries();
        logic [OUT_WIDTH-1:0] exp;
        logic [1:0] s7;
        exp = exp_frame(1);
        out_ready = 1'b1;
        send_words(0, 48, 1, 47);
        s7 = out_data[15:14];
        checks++; if (out_data !== exp) begin errors++; $display("FAIL bound_data: got %h want %h", out_data, exp); end
        checks++; if (s7 !== 2'b11) begin errors++; $display("FAIL bound_ffff: got %b want 11", s7); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [OUT_WIDTH-1:0] fa;
        logic [OUT_WIDTH-1:0] fb;
        fa = exp_frame(0);
        fb = exp_frame(1);
        out_ready = 1'b0;
        tick();
        send_words(0, 48, 0, 47);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
        send_words(0, 48, 1, 47);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
        checks++; if (out_data !== fa) begin errors++; $display("FAIL bp_first_held: got %h want %h", out_data, fa); end
        tick(); tick();
        checks++; if (out_data !== fa || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h/%b want %h/1", out_data, out_valid, fa); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== fb) begin errors++; $display("FAIL bp_second_data: got %h want %h", out_data, fb); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int st0;
        logic [OUT_WIDTH-1:0] f1;
        logic [OUT_WIDTH-1:0] f2;
        f1 = exp_frame(1);
        f2 = exp_frame(2);
        out_ready = 1'b1;
        st0 = stalls;
        send_words(0, 48, 1, 47);
        checks++; if (out_valid !== 1'b1 || out_data !== f1) begin errors++; $display("FAIL b2b_first: got %h/%b want %h/1", out_data, out_valid, f1); end
        send_words(0, 48, 2, 47);
        checks++; if (out_valid !== 1'b1 || out_data !== f2) begin errors++; $display("FAIL b2b_second: got %h/%b want %h/1", out_data, out_valid, f2); end
        checks++; if (stalls - st0 !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", stalls - st0); end
        tick();
    endtask

    task automatic test_early_last();
        int e0;
        logic [OUT_WIDTH-1:0] f2;
        f2 = exp_frame(2);
        out_ready = 1'b1;
        e0 = err_pulses;
        send_words(0, 11, 1, 10);
        checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", err_frame); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_no_out: got %b want 0", out_valid); end
        tick();
        checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL early_err_pulse: got %b want 0", err_frame); end
        send_words(0, 48, 2, 47);
        checks++; if (out_valid !== 1'b1 || out_data !== f2) begin errors++; $display("FAIL early_next: got %h/%b want %h/1", out_data, out_valid, f2); end
        tick();
        checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL early_err_count: got %0d want 1", err_pulses - e0); end
    endtask

    task automatic test_no_last();
        logic [OUT_WIDTH-1:0] f1;
        f1 = exp_frame(1);
        out_ready = 1'b1;
        send_words(0, 48, 1, -1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nolast_valid: got %b want 1", out_valid); end
        checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b want 1", err_frame); end
        checks++; if (out_data !== f1) begin errors++; $display("FAIL nolast_data: got %h want %h", out_data, f1); end
        tick();
        checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL nolast_err_pulse: got %b want 0", err_frame); end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic [OUT_WIDTH-1:0] f2;
        f2 = exp_frame(2);
        out_ready = 1'b0;
        send_words(0, 48, 0, 47);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_held: got %b want 1", out_valid); end
        e0 = err_pulses;
        send_words(0, 20, 1, -1);
        in_valid = 1'b1;
        in_data  = word_for(1, 20);
        rst      = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rmid_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL rmid_err: got %0d pulses want 0", err_pulses - e0); end
        send_words(0, 48, 2, 47);
        checks++; if (out_valid !== 1'b1 || out_data !== f2) begin errors++; $display("FAIL rmid_next: got %h/%b want %h/1", out_data, out_valid, f2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_early_last();
        test_no_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
